// File: rtl/branch_resolve_unit_pkg.sv
// Shared pipeline definitions for ID-stage branch resolution:
// branch encodings, forwarding selects and the BTB entry layout.
package branch_resolve_unit_pkg;

  localparam int XLEN        = 32;
  localparam int BTB_ENTRIES = 16;
  localparam int IDX         = $clog2(BTB_ENTRIES);
  localparam int TAG_W       = XLEN - IDX - 2;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam logic [1:0] CTR_RST = 2'b01;
  localparam logic [1:0] CTR_NEW = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       t
  );
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side prediction and ID-side resolve bundle of the
// branch resolver; the unit sits on the slave modport.
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;

  logic [XLEN-1:0] pc_IF;
  logic            pred_taken_IF;
  logic [XLEN-1:0] pred_target_IF;

  logic            valid_ID;
  logic            Branch_ID;
  logic            stall_ID;
  logic [2:0]      funct3_ID;
  logic [XLEN-1:0] pc_ID;
  logic [XLEN-1:0] imm_ID;
  logic            pred_taken_ID;
  logic [XLEN-1:0] pred_target_ID;
  logic [XLEN-1:0] rs1_data_ID;
  logic [XLEN-1:0] rs2_data_ID;
  logic [XLEN-1:0] aluResult_EX;
  logic [XLEN-1:0] aluResult_MEM;
  logic [1:0]      branch_forwardA;
  logic [1:0]      branch_forwardB;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            IFFlush;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output pc_IF, valid_ID, Branch_ID, stall_ID,
    output funct3_ID, pc_ID, imm_ID,
    output pred_taken_ID, pred_target_ID,
    output rs1_data_ID, rs2_data_ID,
    output aluResult_EX, aluResult_MEM,
    output branch_forwardA, branch_forwardB,
    input  pred_taken_IF, pred_target_IF,
    input  redirect, redirect_pc, IFFlush,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  pc_IF, valid_ID, Branch_ID, stall_ID,
    input  funct3_ID, pc_ID, imm_ID,
    input  pred_taken_ID, pred_target_ID,
    input  rs1_data_ID, rs2_data_ID,
    input  aluResult_EX, aluResult_MEM,
    input  branch_forwardA, branch_forwardB,
    output pred_taken_IF, pred_target_IF,
    output redirect, redirect_pc, IFFlush,
    output branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_resolve_unit_btb_table.sv
// Direct-mapped BTB: combinational IF read port and a
// read-modify-write update port driven from ID.
module branch_resolve_unit_btb_table
  import branch_resolve_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX-1:0]   rd_idx_i,
  output btb_entry_t       rd_entry_o,
  input  logic             upd_i,
  input  logic [IDX-1:0]   upd_idx_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_taken_i
);

  btb_entry_t mem_q [BTB_ENTRIES];
  btb_entry_t cur;
  btb_entry_t mem_d;
  logic       hit;
  logic       we;

  always_comb begin
    cur   = mem_q[upd_idx_i];
    hit   = cur.valid && (cur.tag == upd_tag_i);
    mem_d = cur;
    we    = 1'b0;
    if (upd_i) begin
      if (hit) begin
        we        = 1'b1;
        mem_d.ctr = ctr_next(cur.ctr, upd_taken_i);
        if (upd_taken_i) mem_d.target = upd_target_i;
      end else if (upd_taken_i) begin
        we           = 1'b1;
        mem_d.valid  = 1'b1;
        mem_d.tag    = upd_tag_i;
        mem_d.target = upd_target_i;
        mem_d.ctr    = CTR_NEW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[i].valid  <= 1'b0;
        mem_q[i].tag    <= '0;
        mem_q[i].target <= '0;
        mem_q[i].ctr    <= CTR_RST;
      end
    end else if (we) begin
      mem_q[upd_idx_i] <= mem_d;
    end
  end

  // IF sees pre-write contents on a same-index collision
  assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: forwarded compare, mispredict
// redirect/flush, BTB fetch prediction and perf counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  btb_entry_t      rd_e;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthrough;
  logic            taken;
  logic            br_valid;
  logic            resolve;
  logic            mispredict;
  logic            redirect;
  logic            hit_if;
  logic [31:0]     branch_count_q, branch_count_d;
  logic [31:0]     mispred_count_q, mispred_count_d;

  always_comb begin
    unique case (bus.branch_forwardA)
      FWD_EX:  op_a = bus.aluResult_EX;
      FWD_MEM: op_a = bus.aluResult_MEM;
      default: op_a = bus.rs1_data_ID;
    endcase
    unique case (bus.branch_forwardB)
      FWD_EX:  op_b = bus.aluResult_EX;
      FWD_MEM: op_b = bus.aluResult_MEM;
      default: op_b = bus.rs2_data_ID;
    endcase
  end

  always_comb begin
    taken    = 1'b0;
    br_valid = 1'b1;
    case (bus.funct3_ID)
      BR_BEQ:  taken = (op_a == op_b);
      BR_BNE:  taken = (op_a != op_b);
      BR_BLT:  taken = ($signed(op_a) <  $signed(op_b));
      BR_BGE:  taken = ($signed(op_a) >= $signed(op_b));
      BR_BLTU: taken = (op_a <  op_b);
      BR_BGEU: taken = (op_a >= op_b);
      default: br_valid = 1'b0;
    endcase
  end

  assign resolve = bus.valid_ID & bus.Branch_ID
                 & ~bus.stall_ID & ~rst;
  assign target      = bus.pc_ID + bus.imm_ID;
  assign fallthrough = bus.pc_ID + XLEN'(4);

  assign mispredict = (taken != bus.pred_taken_ID)
                    | (taken & bus.pred_taken_ID
                       & (bus.pred_target_ID != target));

  assign redirect        = resolve & mispredict;
  assign bus.redirect    = redirect;
  assign bus.IFFlush     = redirect;
  assign bus.redirect_pc = (redirect & taken) ? target : fallthrough;

  branch_resolve_unit_btb_table u_btb_table (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_i     (bus.pc_IF[IDX+1:2]),
    .rd_entry_o   (rd_e),
    .upd_i        (resolve & br_valid),
    .upd_idx_i    (bus.pc_ID[IDX+1:2]),
    .upd_tag_i    (bus.pc_ID[XLEN-1:IDX+2]),
    .upd_target_i (target),
    .upd_taken_i  (taken)
  );

  assign hit_if = rd_e.valid
                & (rd_e.tag == bus.pc_IF[XLEN-1:IDX+2]);
  assign bus.pred_taken_IF  = hit_if & rd_e.ctr[1];
  assign bus.pred_target_IF = (hit_if & rd_e.ctr[1])
                            ? rd_e.target
                            : bus.pc_IF + XLEN'(4);

  assign branch_count_d  = branch_count_q + 32'(resolve);
  assign mispred_count_d = mispred_count_q + 32'(redirect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispred_count_q;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch resolver and fetch predictor for the 5-stage RV32I pipeline. It consumes the branch operand forwarding selects and the stall decision made upstream in ID. It evaluates the branch condition on forwarded operands, detects mispredictions, and issues the PC redirect and IF/ID flush. It also owns a direct-mapped BTB with 2-bit counters that predicts fetch direction and target in IF, plus two performance counters.

## Interface
- XLEN, 32: datapath and PC width.
- BTB_ENTRIES, 16: BTB depth; power of two, at least 2. IDX = log2(BTB_ENTRIES).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc_IF  in  XLEN  current fetch PC.
- pred_taken_IF  out  1  BTB predicts taken.
- pred_target_IF  out  XLEN  next fetch PC: BTB target if predicted taken, else pc_IF+4.
- valid_ID  in  1  ID holds a real instruction (0 = bubble).
- Branch_ID  in  1  ID instruction is a conditional branch.
- stall_ID  in  1  upstream hazard logic is holding ID this cycle.
- funct3_ID  in  3  branch type.
- pc_ID, imm_ID  in  XLEN each  branch PC; sign-extended B-immediate.
- pred_taken_ID, pred_target_ID  in  1 / XLEN  IF prediction carried through IF/ID.
- rs1_data_ID, rs2_data_ID  in  XLEN each  register file read data.
- aluResult_EX, aluResult_MEM  in  XLEN each  forwarding sources.
- branch_forwardA, branch_forwardB  in  2 each  operand select: 10 = EX, 01 = MEM, 00 = RF, 11 = RF.
- redirect  out  1  fetch must load redirect_pc.
- redirect_pc  out  XLEN  corrected next PC.
- IFFlush  out  1  squash the IF/ID register; always equals redirect.
- branch_count, mispredict_count  out  32 each  performance counters.

## Operation
- Operand A is rs1_data_ID, aluResult_EX or aluResult_MEM, chosen by branch_forwardA. Operand B is chosen the same way by branch_forwardB.
- Branch condition by funct3:
  - 000 beq, 001 bne: equality.
  - 100 blt, 101 bge: signed compare.
  - 110 bltu, 111 bgeu: unsigned compare.
  - 010 and 011: not taken, no BTB update, still counted as a branch.
- resolve = valid_ID & Branch_ID & !stall_ID & !rst. Nothing below happens unless resolve is 1.
- target = pc_ID + imm_ID, modulo 2^XLEN. fallthrough = pc_ID + 4, also wrapping.
- mispredict = (taken != pred_taken_ID) | (taken & pred_taken_ID & pred_target_ID != target).
- On mispredict: redirect = 1, and redirect_pc = taken ? target : fallthrough. Otherwise redirect = 0 and redirect_pc = fallthrough.
- BTB index is pc[IDX+1:2] and tag is pc[XLEN-1:IDX+2]. Each entry holds valid, tag, target and a 2-bit counter.
- BTB lookup (combinational on pc_IF): a hit with ctr[1]=1 predicts taken with the stored target. Any other case predicts not taken with pc_IF+4.
- BTB update on resolve, indexed by pc_ID:
  - Hit: the counter saturates up when taken and down when not taken (11 and 00 hold). The target is written when taken.
  - Miss and taken: allocate with valid=1, the new tag, target, and ctr=10.
  - Miss and not taken: no change.
- Counters: branch_count increments on every resolve. mispredict_count increments on resolve & mispredict. Both wrap modulo 2^32.

## Timing
- Prediction, compare, redirect and IFFlush are combinational in the same cycle. This gives a one-cycle mispredict penalty, because only the IF/ID slot is flushed.
- BTB and counter writes take effect at the rising edge that ends the resolve cycle.
- Same-index read and write in one cycle: the IF read returns the pre-write contents.
- While stall_ID is held, the branch resolves exactly once, in the first cycle stall_ID is 0. Stall cycles cause no redirect and no update.
- A bubble (valid_ID=0) never redirects, even if Branch_ID is stale-high.
- Values while rst is asserted:
  - redirect = 0, IFFlush = 0, redirect_pc = pc_ID+4.
  - Every BTB valid bit = 0 and every counter = 01.
  - branch_count = mispredict_count = 0.
  - pred_taken_IF = 0 and pred_target_IF = pc_IF+4 from the first cycle after reset.
- Assertion of rst takes effect immediately, mid-operation, and discards any write due at the next edge.

## Structure
- The shared pipeline package holds:
  - funct3 branch encodings (BR_BEQ…BR_BGEU).
  - Forward-select constants FWD_RF=00, FWD_MEM=01, FWD_EX=10.
  - The btb_entry_t struct and the counter reset value 2'b01.
- btb_table is one sub-module: one combinational read port for IF and one synchronous write port for ID, with an async clear. The resolver instantiates it.

## Test plan
- beq, x1=x2=5 read from the RF, pred_taken_ID=0, pc_ID=0x100, imm=0x20 -> redirect=1, redirect_pc=0x120, IFFlush=1; BTB[0] allocated with ctr=10; both counters = 1.
- The same branch fetched again at pc_IF=0x100 -> pred_taken_IF=1, pred_target_IF=0x120. Resolving it taken with matching prediction -> redirect=0, ctr=11.
- bne with forwardA=10, aluResult_EX=7, rs2=7, predicted taken -> not taken; redirect_pc=pc_ID+4; ctr goes 11 -> 10.
- blt with -1 vs 1 -> taken; bltu with the same operands -> not taken.
- stall_ID=1 for 2 cycles, then 0 -> exactly one resolve and one branch_count increment; no redirect during the stall.
- Assert rst between a resolving cycle and the clock edge -> no BTB write; pred_taken_IF=0 afterwards; counters = 0.
